// File: rtl/apb4_master_if.sv
// APB4 bus bundle between one initiator and the interconnect.
interface apb4_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_master.sv
// APB4 initiator: one outstanding valid/ready command -> SETUP/ACCESS transfer
// -> valid/ready response, with an optional ACCESS-phase timeout.
module apb4_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  apb4_intf.master                apb_o
);

  // A disabled timeout still needs a legal 1-bit counter declaration.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  assign req_ready_o = (state == IDLE);

  // cnt holds the number of earlier wait cycles, so cnt == LIMIT marks the last allowed cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !apb_o.pready && (cnt == LIMIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (apb_o.pready || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      apb_o.psel    <= 1'b0;
      apb_o.penable <= 1'b0;
      apb_o.pwrite  <= 1'b0;
      apb_o.paddr   <= '0;
      apb_o.pwdata  <= '0;
      apb_o.pstrb   <= '0;
      apb_o.pprot   <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      cnt           <= '0;
    end else begin
      apb_o.psel    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      apb_o.penable <= (state_nxt == ACCESS);
      rsp_valid_o   <= (state_nxt == RESP);
      if (state == IDLE && req_valid_i) begin
        apb_o.pwrite <= req_write_i;
        apb_o.paddr  <= req_addr_i;
        apb_o.pwdata <= req_wdata_i;
        apb_o.pprot  <= req_prot_i;
        apb_o.pstrb  <= req_write_i ? req_strb_i : '0;
      end
      if (state == ACCESS) begin
        if (state_nxt == RESP) begin
          cnt         <= '0;
          rsp_err_o   <= apb_o.pready ? apb_o.pslverr : 1'b1;
          rsp_rdata_o <= (apb_o.pready && !apb_o.pwrite) ? apb_o.prdata : '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_apb4_master.sv
// Randomized bench for apb4_master: scripted slave wait/error profile per
// transfer, expected response and timing derived from the APB4 transfer rules.
module tb_apb4_master;
  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_strb_i = '0;
  logic [2:0]  req_prot_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  apb4_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  apb4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i), .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .apb_o(apb)
  );

  always #5 clk_i = ~clk_i;

  // slave: holds PREADY low for s_wait ACCESS cycles, then completes
  int          s_wait = 0;
  logic        s_err = 1'b0;
  logic [31:0] s_rdata = '0;
  int          acc_cnt = 0;

  always @(posedge clk_i)
    acc_cnt <= (apb.psel && apb.penable && !apb.pready) ? acc_cnt + 1 : 0;

  assign apb.pready  = apb.psel && apb.penable && (acc_cnt >= s_wait);
  assign apb.pslverr = apb.pready && s_err;
  assign apb.prdata  = s_rdata;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: wait states below the timeout give w+1 ACCESS cycles and the
  // slave's answer; otherwise the transfer is cut after TO cycles with an error.
  task automatic model(input int w, input logic wr, input logic err, input logic [31:0] rd,
                       output int acc, output logic e_err, output logic [31:0] e_rd);
    if (w < TO) begin
      acc = w + 1; e_err = err; e_rd = wr ? 32'h0 : rd;
    end else begin
      acc = TO; e_err = 1'b1; e_rd = 32'h0;
    end
  endtask

  logic        presented = 1'b0;
  logic        n_wr;
  logic [31:0] n_addr, n_wdata;
  logic [3:0]  n_strb;
  logic [2:0]  n_prot;

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input int w,
                         input logic err, input logic [31:0] rd, input int rdly, input logic chain);
    int acc, waited, cyc, pen;
    logic e_err, bad, hbad;
    logic [31:0] e_rd, h_rd;
    logic h_err;
    model(w, wr, err, rd, acc, e_err, e_rd);
    s_wait = w; s_err = err; s_rdata = rd;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr;
    req_wdata_i = wdata; req_strb_i = strb; req_prot_i = prot;
    waited = 0;
    while (!req_ready_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    if (waited >= 20) begin
      chk("accept_timeout", 64'(waited), 64'd0);
      req_valid_i = 1'b0;
      return;
    end
    if (presented) chk("b2b_accept_delay", 64'(waited), 64'd0);
    presented = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    chk("setup_phase", {62'd0, apb.psel, apb.penable}, 64'b10);
    cyc = 1; pen = 0; bad = 1'b0;
    while (!rsp_valid_o && cyc < 60) begin
      if (apb.psel && !(apb.pwrite == wr && apb.paddr == addr && apb.pprot == prot &&
                        apb.pstrb == (wr ? strb : 4'h0) && (!wr || apb.pwdata == wdata)))
        bad = 1'b1;
      if (apb.penable) pen++;
      @(posedge clk_i); #1;
      cyc++;
    end
    chk("rsp_latency", 64'(cyc), 64'(acc + 2));
    chk("penable_cycles", 64'(pen), 64'(acc));
    chk("apb_fields", {63'd0, bad}, 64'd0);
    chk("psel_in_resp", {63'd0, apb.psel}, 64'd0);
    chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, e_err});
    chk("rsp_rdata", {32'd0, rsp_rdata_o}, {32'd0, e_rd});
    h_rd = rsp_rdata_o; h_err = rsp_err_o; hbad = 1'b0;
    if (chain) begin
      @(negedge clk_i);
      req_valid_i = 1'b1; req_write_i = n_wr; req_addr_i = n_addr;
      req_wdata_i = n_wdata; req_strb_i = n_strb; req_prot_i = n_prot;
    end
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk_i); #1;
      if (!rsp_valid_o || rsp_rdata_o != h_rd || rsp_err_o != h_err || req_ready_o || apb.psel)
        hbad = 1'b1;
    end
    if (rdly > 0) chk("resp_hold", {63'd0, hbad}, 64'd0);
    @(negedge clk_i);
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    chk("handshake", {62'd0, rsp_valid_o, req_ready_o}, 64'b01);
    presented = chain;
  endtask

  initial begin
    logic bad;
    #12;
    chk("rst_apb_ctl", {61'd0, apb.psel, apb.penable, apb.pwrite}, 64'd0);
    chk("rst_apb_data", {apb.paddr, apb.pwdata}, 64'd0);
    chk("rst_apb_strb_prot", {57'd0, apb.pstrb, apb.pprot}, 64'd0);
    chk("rst_rsp", {30'd0, rsp_valid_o, rsp_err_o, rsp_rdata_o}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
    rst_ni = 1'b1;

    run_txn(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 32'h1111_2222, 0, 1'b0);
    run_txn(1'b0, 32'h4000_0020, 32'h0BAD_F00D, 4'hF, 3'd2, 3, 1'b0, 32'h1234_5678, 1, 1'b0);
    // slave error, next command held pending during the response
    n_wr = 1'b0; n_addr = 32'h4000_0030; n_wdata = 32'h0; n_strb = 4'h3; n_prot = 3'd1;
    run_txn(1'b1, 32'h4000_0024, 32'hCAFE_0001, 4'h5, 3'd4, 0, 1'b1, 32'h0, 2, 1'b1);
    run_txn(n_wr, n_addr, n_wdata, n_strb, n_prot, 0, 1'b0, 32'h7777_8888, 0, 1'b0);
    // timeout, then PREADY exactly on the last allowed cycle
    run_txn(1'b0, 32'h4000_0040, 32'h0, 4'h0, 3'd0, 1000, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
    run_txn(1'b0, 32'h4000_0044, 32'h0, 4'h0, 3'd0, TO - 1, 1'b0, 32'hA5A5_A5A5, 0, 1'b0);
    run_txn(1'b1, 32'h4000_0048, 32'h5555_AAAA, 4'hC, 3'd7, 1000, 1'b0, 32'h0, 0, 1'b0);
    // response backpressure with the next command waiting
    n_wr = 1'b1; n_addr = 32'h4000_0050; n_wdata = 32'h0102_0304; n_strb = 4'h9; n_prot = 3'd3;
    run_txn(1'b0, 32'h4000_004C, 32'h0, 4'hF, 3'd5, 2, 1'b0, 32'h9ABC_DEF0, 5, 1'b1);
    run_txn(n_wr, n_addr, n_wdata, n_strb, n_prot, 1, 1'b0, 32'h0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int w;
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 4) : $urandom_range(0, 4);
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 3'($urandom), w,
              ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3), 1'b0);
    end

    // async reset in the middle of an ACCESS cycle
    s_wait = 1000;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h4000_0060;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); @(posedge clk_i);
    #3;
    chk("pre_rst_access", {62'd0, apb.psel, apb.penable}, 64'b11);
    rst_ni = 1'b0;
    #1;
    chk("rst_drop", {61'd0, apb.psel, apb.penable, rsp_valid_o}, 64'd0);
    #10;
    rst_ni = 1'b1;
    s_wait = 0;
    chk("rst_req_ready_after", {63'd0, req_ready_o}, 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o || apb.psel) bad = 1'b1;
    end
    chk("no_stale_rsp", {63'd0, bad}, 64'd0);
    run_txn(1'b0, 32'h4000_0070, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h3C3C_C3C3, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/apb4_master.md
Name: apb4_master

Overview:
- APB4 initiator. Converts a single-outstanding valid/ready command channel into APB4 SETUP/ACCESS transfers on an apb4_intf master port, and returns read data and error status on a valid/ready response channel.
- Drives the master side of the APB4 interconnect, so CPU/DMA-side logic reaches the peripheral address map through the APB mux.
- Includes an optional ACCESS-phase timeout so a hung slave cannot stall the requester.

Parameters:
ADDR_WIDTH, 32, APB address width.
DATA_WIDTH, 32, APB data width; must be a multiple of 8.
TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before forced error completion; 0 disables the timeout.

Ports:
clk_i  input  1  clock; all logic is rising-edge.
rst_ni  input  1  asynchronous, active-low reset.
req_valid_i  input  1  command valid.
req_ready_o  output  1  command accepted when high together with req_valid_i.
req_write_i  input  1  1 = write, 0 = read.
req_addr_i  input  ADDR_WIDTH  target address.
req_wdata_i  input  DATA_WIDTH  write data.
req_strb_i  input  DATA_WIDTH/8  write byte strobes.
req_prot_i  input  3  PPROT value.
rsp_valid_o  output  1  response valid.
rsp_ready_i  input  1  response consumed.
rsp_rdata_o  output  DATA_WIDTH  read data; 0 for writes and for timeouts.
rsp_err_o  output  1  PSLVERR, or timeout.
apb_o  apb4_intf.master  -  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT out; PRDATA, PREADY, PSLVERR in.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - PSEL, PENABLE, PWRITE = 0.
  - PADDR, PWDATA, PSTRB, PPROT = 0.
  - rsp_valid_o, rsp_rdata_o, rsp_err_o = 0.
  - Timeout counter = 0.
- req_ready_o is combinational: high iff state == IDLE.
- Reset assertion mid-transfer:
  - Drops PSEL/PENABLE and rsp_valid_o immediately, without waiting for a clock edge.
  - Any in-flight command is discarded with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On req_valid_i && req_ready_o, register PWRITE, PADDR, PWDATA and PPROT.
  - PSTRB = req_strb_i for writes; forced to 0 for reads (APB4 rule).
  - Go to SETUP. All APB outputs are registered.
- SETUP: PSEL = 1, PENABLE = 0. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - Address, control and write data stay stable from SETUP through the end of ACCESS.
  - Counter increments each ACCESS cycle that has PREADY = 0.
- Completion from ACCESS, evaluated at the rising edge:
  - PREADY = 1: capture rsp_err_o = PSLVERR. Capture rsp_rdata_o = PRDATA for reads, 0 for writes. Go to RESP.
  - PREADY = 0 and TIMEOUT_CYCLES != 0 and this is the TIMEOUT_CYCLES-th ACCESS cycle: rsp_err_o = 1, rsp_rdata_o = 0, go to RESP.
  - PREADY = 1 on that same final cycle takes priority: normal completion.
  - On leaving ACCESS: PSEL = 0, PENABLE = 0, counter cleared. PADDR, PWDATA, PWRITE, PPROT hold their last values; PSTRB holds too.
- RESP:
  - rsp_valid_o = 1. rsp_rdata_o and rsp_err_o are held stable.
  - On rsp_ready_i = 1: rsp_valid_o = 0 next cycle, return to IDLE.
  - No APB activity and no command acceptance while in RESP.
- Latency:
  - Accept at edge N: SETUP during cycle N+1, ACCESS from N+2.
  - Zero-wait slave: rsp_valid_o high in cycle N+3.
  - Each PREADY wait state adds 1 cycle.
  - Minimum issue interval: 4 cycles per transfer.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1). It never wraps, because ACCESS is bounded.
- Addresses are passed through unchanged; no alignment or range checking.

Test Plan:
- Zero-wait write: addr 0x4000_0010, wdata 0xDEADBEEF, strb 0xF, PREADY tied 1 -> PSEL rises cycle N+1, PENABLE cycle N+2, rsp_valid_o cycle N+3, rsp_err_o = 0, rsp_rdata_o = 0, PSTRB = 0xF.
- Read, 3 wait states: PREADY rises on 4th ACCESS cycle with PRDATA = 0x1234_5678 -> PENABLE high exactly 4 cycles, PSTRB = 0 throughout, PADDR stable, rsp_rdata_o = 0x1234_5678.
- Slave error: write with PREADY = 1, PSLVERR = 1 -> rsp_err_o = 1; next command accepted only after the response handshake.
- Timeout with TIMEOUT_CYCLES = 16 and PREADY stuck 0 -> PENABLE high exactly 16 cycles, then rsp_err_o = 1, rsp_rdata_o = 0. Rerun with PREADY = 1 on the 16th cycle and PRDATA = 0xA5A5_A5A5 -> normal completion, rsp_err_o = 0, rsp_rdata_o = 0xA5A5_A5A5.
- Response backpressure: rsp_ready_i low for 5 cycles with req_valid_i held high -> rsp_valid_o/rsp_rdata_o stable, req_ready_o = 0, PSEL = 0; next SETUP begins 2 cycles after the response handshake.
- Async reset during ACCESS, asserted mid-cycle -> PSEL, PENABLE and rsp_valid_o drop before the next edge; req_ready_o = 1 after release; no stale response is delivered.
